wdt_rst_ctrl: RTL and testbench

- Downstream stage of the watchdog timer. Consumes its overflow pulse (reset_wdt) plus a software reset request.
- Generates a fixed-width, registered system reset pulse, followed by a blanking window that suppresses re-triggering.
- Keeps a sticky reset-cause register and a saturating reset counter for boot firmware.
- Lives in the always-on domain; is never reset by its own output.

---
 rtl/wdt_rst_ctrl.sv | 128 ++++++++++++
 tb/tb_wdt_rst_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_rst_ctrl.sv
// wdt_rst_ctrl: turns a watchdog overflow or a software request into a
// fixed-width registered system reset pulse, then blanks further requests
// for a quiet window. Tracks a sticky reset cause, a sticky "request dropped"
// flag and a saturating count of accepted reset events.
module wdt_rst_ctrl #(
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned QUIET_CYCLES = 8,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wdt_ovf_i,
    input  logic                 wdt_en_i,
    input  logic                 sw_rst_req_i,
    input  logic                 clear_cause_i,
    output logic                 sys_rst_o,
    output logic                 busy_o,
    output logic [1:0]           cause_o,
    output logic                 dropped_o,
    output logic [CNT_WIDTH-1:0] rst_count_o
);

    localparam int unsigned MAX_LOAD = (HOLD_CYCLES > QUIET_CYCLES) ? HOLD_CYCLES : QUIET_CYCLES;
    localparam int unsigned TW       = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] QUIET_LOAD = TW'((QUIET_CYCLES == 0) ? 0 : QUIET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ASSERT = 2'b01,
        S_QUIET  = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 sys_rst_q, sys_rst_d;
    logic [1:0]           cause_q, cause_d;
    logic                 dropped_q, dropped_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic wdt_req;
    logic req;

    assign wdt_req = wdt_ovf_i & wdt_en_i;
    assign req     = wdt_req | sw_rst_req_i;

    // Next-state, timer, sticky flags and event counter.
    // Clear is applied first so that a set on the same edge overrides it and
    // leaves only the newly set bits.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cause_d   = clear_cause_i ? 2'b00 : cause_q;
        dropped_d = dropped_q & ~clear_cause_i;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_ASSERT;
                    tmr_d   = HOLD_LOAD;
                    cause_d = cause_d | {sw_rst_req_i, wdt_req};
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ASSERT: begin
                if (req) begin
                    dropped_d = 1'b1;
                end
                if (tmr_q == '0) begin
                    if (QUIET_CYCLES == 0) begin
                        state_d = S_IDLE;
                        tmr_d   = '0;
                    end else begin
                        state_d = S_QUIET;
                        tmr_d   = QUIET_LOAD;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_QUIET: begin
                if (req) begin
                    dropped_d = 1'b1;
                end
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase

        sys_rst_d = (state_d == S_ASSERT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            sys_rst_q <= 1'b0;
            cause_q   <= '0;
            dropped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            sys_rst_q <= sys_rst_d;
            cause_q   <= cause_d;
            dropped_q <= dropped_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sys_rst_o   = sys_rst_q;
    assign busy_o      = (state_q != S_IDLE);
    assign cause_o     = cause_q;
    assign dropped_o   = dropped_q;
    assign rst_count_o = cnt_q;

endmodule

// File: tb/tb_wdt_rst_ctrl.sv
// Bench for wdt_rst_ctrl: three instances (defaults, 2-bit counter,
// HOLD=1/QUIET=0). Per-cycle scoreboard against a behavioural model, plus a
// hand-computed stimulus table and hand-written multi-cycle sequences.
module tb_wdt_rst_ctrl;

    typedef struct packed {
        logic rst;
        logic ovf;
        logic en;
        logic sw;
        logic clr;
    } in_t;

    typedef struct packed {
        int unsigned h;
        int unsigned q;
        logic [1:0]  cause;
        logic        drop;
        int unsigned cnt;
    } mdl_t;

    typedef struct {
        in_t         x;
        int unsigned n;
        logic [12:0] e;
    } row_t;

    localparam in_t I_IDLE  = 5'b00000;
    localparam in_t I_RST   = 5'b10000;
    localparam in_t I_OVF   = 5'b01100;
    localparam in_t I_OVFNE = 5'b01000;
    localparam in_t I_SW    = 5'b00010;
    localparam in_t I_BOTH  = 5'b01110;
    localparam in_t I_CLR   = 5'b00001;
    localparam in_t I_OVFCL = 5'b01101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t in_a, in_b, in_c;

    logic       a_sys, a_busy, a_drop;
    logic [1:0] a_cause;
    logic [7:0] a_cnt;
    logic       b_sys, b_busy, b_drop;
    logic [1:0] b_cause;
    logic [1:0] b_cnt;
    logic       c_sys, c_busy, c_drop;
    logic [1:0] c_cause;
    logic [7:0] c_cnt;

    wdt_rst_ctrl #(.HOLD_CYCLES(16), .QUIET_CYCLES(8), .CNT_WIDTH(8)) dut_a (
        .clk_i(clk), .rst_i(in_a.rst), .wdt_ovf_i(in_a.ovf), .wdt_en_i(in_a.en),
        .sw_rst_req_i(in_a.sw), .clear_cause_i(in_a.clr), .sys_rst_o(a_sys),
        .busy_o(a_busy), .cause_o(a_cause), .dropped_o(a_drop), .rst_count_o(a_cnt));

    wdt_rst_ctrl #(.HOLD_CYCLES(16), .QUIET_CYCLES(8), .CNT_WIDTH(2)) dut_b (
        .clk_i(clk), .rst_i(in_b.rst), .wdt_ovf_i(in_b.ovf), .wdt_en_i(in_b.en),
        .sw_rst_req_i(in_b.sw), .clear_cause_i(in_b.clr), .sys_rst_o(b_sys),
        .busy_o(b_busy), .cause_o(b_cause), .dropped_o(b_drop), .rst_count_o(b_cnt));

    wdt_rst_ctrl #(.HOLD_CYCLES(1), .QUIET_CYCLES(0), .CNT_WIDTH(8)) dut_c (
        .clk_i(clk), .rst_i(in_c.rst), .wdt_ovf_i(in_c.ovf), .wdt_en_i(in_c.en),
        .sw_rst_req_i(in_c.sw), .clear_cause_i(in_c.clr), .sys_rst_o(c_sys),
        .busy_o(c_busy), .cause_o(c_cause), .dropped_o(c_drop), .rst_count_o(c_cnt));

    int unsigned checks = 0;
    int unsigned errors = 0;

    mdl_t m_a = '0, m_b = '0, m_c = '0;
    logic [12:0] q_a[$], q_b[$], q_c[$];
    row_t tbl[$];

    // Model: h = remaining high cycles, q = remaining quiet cycles.
    function automatic mdl_t step(input mdl_t m, input int unsigned hold,
                                  input int unsigned quiet, input int unsigned cmax,
                                  input in_t x);
        mdl_t       n    = m;
        logic       wr   = x.ovf & x.en;
        logic       req  = wr | x.sw;
        logic [1:0] setb = 2'b00;
        logic       dev  = 1'b0;
        if (x.rst) return '0;
        if (m.h == 0 && m.q == 0) begin
            if (req) begin
                n.h  = hold;
                setb = {x.sw, wr};
                if (n.cnt < cmax) n.cnt = n.cnt + 1;
            end
        end else if (m.h > 0) begin
            dev = req;
            n.h = m.h - 1;
            if (n.h == 0) n.q = quiet;
        end else begin
            dev = req;
            n.q = m.q - 1;
        end
        n.cause = (x.clr ? 2'b00 : m.cause) | setb;
        n.drop  = (x.clr ? 1'b0 : m.drop) | dev;
        return n;
    endfunction

    function automatic logic [12:0] view(input mdl_t m);
        return {m.h != 0, (m.h != 0) || (m.q != 0), m.cause, m.drop, m.cnt[7:0]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_cmp(input string name, inout logic [12:0] q[$], input logic [12:0] act);
        logic [12:0] e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty actual=%h expected=none", name, act);
        end else begin
            e = q.pop_front();
            check(name, {3'b0, act}, {3'b0, e});
        end
    endtask

    // One clock: predict, push, let the edge happen, then pop and compare.
    task automatic tick();
        m_a = step(m_a, 16, 8, 255, in_a);
        m_b = step(m_b, 16, 8, 3, in_b);
        m_c = step(m_c, 1, 0, 255, in_c);
        q_a.push_back(view(m_a));
        q_b.push_back(view(m_b));
        q_c.push_back(view(m_c));
        @(posedge clk);
        #1;
        pop_cmp("sb_a", q_a, {a_sys, a_busy, a_cause, a_drop, a_cnt});
        pop_cmp("sb_b", q_b, {b_sys, b_busy, b_cause, b_drop, 6'b0, b_cnt});
        pop_cmp("sb_c", q_c, {c_sys, c_busy, c_cause, c_drop, c_cnt});
    endtask

    function automatic row_t mk(input in_t x, input int unsigned n, input logic s,
                                input logic b, input logic [1:0] c, input logic d,
                                input logic [7:0] cnt);
        row_t r;
        r.x = x;
        r.n = n;
        r.e = {s, b, c, d, cnt};
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned last_rise;
        int unsigned rises;
        logic        prev;

        in_a = I_RST;
        in_b = I_RST;
        in_c = I_RST;

        // Expected values after the last cycle of each row, computed by hand.
        tbl.push_back(mk(I_RST,   2, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(I_IDLE, 10, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(I_OVF,   1, 1, 1, 2'b01, 0, 1));
        tbl.push_back(mk(I_IDLE, 15, 1, 1, 2'b01, 0, 1));
        tbl.push_back(mk(I_IDLE,  1, 0, 1, 2'b01, 0, 1));
        tbl.push_back(mk(I_IDLE,  7, 0, 1, 2'b01, 0, 1));
        tbl.push_back(mk(I_IDLE,  1, 0, 0, 2'b01, 0, 1));
        tbl.push_back(mk(I_CLR,   1, 0, 0, 2'b00, 0, 1));
        tbl.push_back(mk(I_OVFNE, 5, 0, 0, 2'b00, 0, 1));
        tbl.push_back(mk(I_SW,    1, 1, 1, 2'b10, 0, 2));
        tbl.push_back(mk(I_IDLE, 15, 1, 1, 2'b10, 0, 2));
        tbl.push_back(mk(I_IDLE,  1, 0, 1, 2'b10, 0, 2));
        tbl.push_back(mk(I_IDLE,  8, 0, 0, 2'b10, 0, 2));
        tbl.push_back(mk(I_RST,   1, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(I_BOTH,  1, 1, 1, 2'b11, 0, 1));
        tbl.push_back(mk(I_IDLE,  3, 1, 1, 2'b11, 0, 1));
        tbl.push_back(mk(I_SW,    1, 1, 1, 2'b11, 1, 1));
        tbl.push_back(mk(I_IDLE, 11, 1, 1, 2'b11, 1, 1));
        tbl.push_back(mk(I_IDLE,  1, 0, 1, 2'b11, 1, 1));
        tbl.push_back(mk(I_IDLE,  2, 0, 1, 2'b11, 1, 1));
        tbl.push_back(mk(I_SW,    1, 0, 1, 2'b11, 1, 1));
        tbl.push_back(mk(I_IDLE,  5, 0, 0, 2'b11, 1, 1));
        tbl.push_back(mk(I_CLR,   1, 0, 0, 2'b00, 0, 1));
        tbl.push_back(mk(I_SW,    1, 1, 1, 2'b10, 0, 2));
        tbl.push_back(mk(I_IDLE,  3, 1, 1, 2'b10, 0, 2));
        tbl.push_back(mk(I_RST,   1, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(I_IDLE,  1, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(I_SW,    1, 1, 1, 2'b10, 0, 1));
        tbl.push_back(mk(I_IDLE, 15, 1, 1, 2'b10, 0, 1));
        tbl.push_back(mk(I_IDLE,  1, 0, 1, 2'b10, 0, 1));
        tbl.push_back(mk(I_IDLE,  7, 0, 1, 2'b10, 0, 1));
        tbl.push_back(mk(I_SW,    1, 0, 0, 2'b10, 1, 1));
        tbl.push_back(mk(I_SW,    1, 1, 1, 2'b10, 1, 2));
        tbl.push_back(mk(I_IDLE, 24, 0, 0, 2'b10, 1, 2));

        for (int i = 0; i < tbl.size(); i++) begin
            in_a = tbl[i].x;
            for (int unsigned k = 0; k < tbl[i].n; k++) tick();
            check($sformatf("row%0d", i), {3'b0, a_sys, a_busy, a_cause, a_drop, a_cnt},
                  {3'b0, tbl[i].e});
        end
        in_a = I_IDLE;

        // Held overflow on the 2-bit counter instance: period and saturation,
        // plus clear coinciding with an accept edge.
        in_b = I_RST;
        tick();
        tick();
        in_b = I_SW;
        tick();
        check("b_sw_cause", {14'b0, b_cause}, 16'h0002);
        in_b = I_IDLE;
        for (int k = 0; k < 24; k++) tick();
        check("b_idle_busy", {15'b0, b_busy}, 16'h0000);
        in_b = I_OVFCL;
        tick();
        check("b_clr_vs_set", {14'b0, b_cause}, 16'h0001);
        check("b_cnt2", {14'b0, b_cnt}, 16'h0002);
        in_b = I_OVF;
        prev = b_sys;
        last_rise = 0;
        rises = 0;
        for (int unsigned k = 1; k <= 80; k++) begin
            tick();
            if (b_sys && !prev) begin
                check("b_period", 16'(k - last_rise), 16'd25);
                last_rise = k;
                rises++;
            end
            prev = b_sys;
        end
        check("b_rises", 16'(rises), 16'd3);
        check("b_cnt_sat", {14'b0, b_cnt}, 16'h0003);
        in_b = I_RST;

        // HOLD=1, QUIET=0 with held software request: 1,0,1,0 pattern.
        in_c = I_RST;
        tick();
        tick();
        in_c = I_SW;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("c_sys%0d", i), {15'b0, c_sys}, (i % 2 == 0) ? 16'd1 : 16'd0);
            check($sformatf("c_cnt%0d", i), {8'b0, c_cnt}, 16'(i / 2 + 1));
        end
        in_c = I_IDLE;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
